// File: rtl/astro_rom_loader.sv
// Download sequencer for the BIOS and cartridge ROM images: routes ioctl writes into the
// two RAMs, pads short cartridges with FILL_BYTE and holds the console in reset while loading.
module astro_rom_loader #(
   parameter int          ADDR_W      = 13,
   parameter logic [7:0]  FILL_BYTE   = 8'hFF,
   parameter int          POST_CYCLES = 16,
   parameter logic [7:0]  BIOS_INDEX  = 8'd0,
   parameter logic [7:0]  CART_INDEX  = 8'd1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              ioctl_wr,
   output logic              ioctl_wait,
   input  logic [ADDR_W-1:0] cpu_cart_addr,
   input  logic [ADDR_W-1:0] cpu_bios_addr,
   output logic [ADDR_W-1:0] cart_addr,
   output logic [ADDR_W-1:0] bios_addr,
   output logic [7:0]        mem_data,
   output logic              cart_we,
   output logic              bios_we,
   output logic [ADDR_W:0]   cart_size,
   output logic [ADDR_W-1:0] cart_mask,
   output logic              core_reset,
   output logic              busy
);

   localparam int              PW        = $clog2(POST_CYCLES + 1);
   localparam logic [PW-1:0]   POST_LAST = PW'(POST_CYCLES - 1);
   localparam logic [ADDR_W:0] IMG_BYTES = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_POST} state_t;

   state_t            r_state;
   logic              r_boot;
   logic [7:0]        r_index;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_fill_ptr;
   logic [7:0]        r_mem_data;
   logic              r_cart_we;
   logic              r_bios_we;
   logic              r_wait;
   logic [ADDR_W:0]   r_cart_size;
   logic [ADDR_W-1:0] r_cart_mask;
   logic [PW-1:0]     r_post_cnt;

   logic              w_in_range;
   logic              w_accept;
   logic [ADDR_W:0]   w_cand;
   logic [ADDR_W:0]   w_size_next;
   logic [ADDR_W-1:0] w_mask_next;

   assign w_in_range = ~(|ioctl_addr[24:ADDR_W]);
   assign w_accept   = (r_state == S_LOAD) && ioctl_wr && w_in_range &&
                       ((r_index == BIOS_INDEX) || (r_index == CART_INDEX));
   assign w_cand     = w_in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1)) : IMG_BYTES;

   // Out-of-range cart writes still count towards the image size (saturating).
   assign w_size_next = ((r_state == S_LOAD) && ioctl_wr && (r_index == CART_INDEX) &&
                         (w_cand > r_cart_size)) ? w_cand : r_cart_size;

   assign w_mask_next = (w_size_next <= (ADDR_W+1)'(2048)) ? ADDR_W'(2047) :
                        (w_size_next <= (ADDR_W+1)'(4096)) ? ADDR_W'(4095) : '1;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_boot      <= 1'b1;
         r_index     <= '0;
         r_wr_addr   <= '0;
         r_fill_ptr  <= '0;
         r_mem_data  <= '0;
         r_cart_we   <= 1'b0;
         r_bios_we   <= 1'b0;
         r_wait      <= 1'b0;
         r_cart_size <= '0;
         r_cart_mask <= '1;
         r_post_cnt  <= '0;
      end else begin
         r_cart_we <= 1'b0;
         r_bios_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_boot) begin
                  // The cycle spent here after reset counts as the first POST cycle.
                  r_boot     <= 1'b0;
                  r_post_cnt <= PW'(1);
                  r_state    <= S_POST;
               end else if (ioctl_download) begin
                  r_index <= ioctl_index;
                  if (ioctl_index == CART_INDEX)
                     r_cart_size <= '0;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_cart_size <= w_size_next;
               if (w_accept) begin
                  r_wr_addr  <= ioctl_addr[ADDR_W-1:0];
                  r_mem_data <= ioctl_dout;
                  r_bios_we  <= (r_index == BIOS_INDEX);
                  r_cart_we  <= (r_index == CART_INDEX);
               end
               if (!ioctl_download) begin
                  r_post_cnt <= '0;
                  r_state    <= S_POST;
                  if (r_index == CART_INDEX) begin
                     r_cart_mask <= w_mask_next;
                     if (w_size_next < IMG_BYTES) begin
                        r_fill_ptr <= w_size_next[ADDR_W-1:0];
                        r_wait     <= 1'b1;
                        r_state    <= S_FILL;
                     end
                  end
               end
            end
            S_FILL: begin
               // Fill writes are registered like loaded bytes, so a strobe coincident
               // with the download falling edge never collides with the first fill byte.
               r_cart_we  <= 1'b1;
               r_wr_addr  <= r_fill_ptr;
               r_mem_data <= FILL_BYTE;
               r_fill_ptr <= r_fill_ptr + ADDR_W'(1);
               r_wait     <= 1'b1;
               if (&r_fill_ptr) begin
                  r_post_cnt <= '0;
                  r_state    <= S_POST;
               end
            end
            S_POST: begin
               r_wait <= 1'b0;
               if (r_post_cnt >= POST_LAST)
                  r_state <= S_IDLE;
               else
                  r_post_cnt <= r_post_cnt + PW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cart_addr  = (r_state == S_IDLE) ? (cpu_cart_addr & r_cart_mask) : r_wr_addr;
   assign bios_addr  = (r_state == S_IDLE) ? cpu_bios_addr : r_wr_addr;
   assign mem_data   = r_mem_data;
   assign cart_we    = r_cart_we;
   assign bios_we    = r_bios_we;
   assign ioctl_wait = r_wait;
   assign cart_size  = r_cart_size;
   assign cart_mask  = r_cart_mask;
   assign busy       = (r_state != S_IDLE);
   assign core_reset = r_boot | (r_state != S_IDLE);

endmodule

// File: doc/astro_rom_loader.md
Name: astro_rom_loader

Overview:
- Sequences HPS ioctl downloads into the two 8 KB on-chip ROM images (BIOS and cartridge).
- Owns the address and write ports of both RAMs, and muxes CPU fetch addresses onto them when idle.
- Pads short cartridge images with 0xFF and derives a power-of-two mirroring mask.
- Holds the console in reset until images are stable. Sits between hps_io and the BIOS/cart dprams; core_reset feeds the BALLY reset.

Parameters:
- ADDR_W, 13, RAM address width (8 KB per image).
- FILL_BYTE, 8'hFF, value written to unloaded cartridge locations.
- POST_CYCLES, 16, clk_sys cycles core_reset stays high after the load completes.
- BIOS_INDEX, 8'd0, ioctl_index selecting the BIOS image.
- CART_INDEX, 8'd1, ioctl_index selecting the cartridge image.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  download target index
- ioctl_addr  in  25  byte address within the image
- ioctl_dout  in  8  download data
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_wait  out  1  stall request to HPS
- cpu_cart_addr  in  13  CPU cartridge fetch address
- cpu_bios_addr  in  13  CPU BIOS fetch address
- cart_addr  out  13  cartridge RAM address
- bios_addr  out  13  BIOS RAM address
- mem_data  out  8  write data for both RAMs
- cart_we  out  1  cartridge RAM write enable
- bios_we  out  1  BIOS RAM write enable
- cart_size  out  14  bytes loaded into the cartridge, saturating at 8192
- cart_mask  out  13  mirroring mask applied to CPU cart addresses
- core_reset  out  1  console reset request
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, LOAD, FILL, POST.
- Reset values:
  - state=IDLE; cart_size=0; cart_mask=13'h1FFF.
  - cart_we=bios_we=0; ioctl_wait=0; mem_data=0.
  - POST counter=0; core_reset=1 while reset is high.
- After reset releases, the FSM enters POST; core_reset stays high for POST_CYCLES cycles, then the FSM goes to IDLE.
- RAM contents are never cleared by reset.
- IDLE:
  - cart_addr = cpu_cart_addr & cart_mask.
  - bios_addr = cpu_bios_addr.
  - Write enables are 0.
  - On ioctl_download=1: go to LOAD and latch the index.
  - If the latched index is CART_INDEX, also clear cart_size to 0.
- LOAD:
  - core_reset=1.
  - A write is accepted when ioctl_wr=1 and ioctl_addr[24:13]==0.
  - An accepted write produces a registered 1-cycle write at N+1: address = ioctl_addr[12:0], mem_data = ioctl_dout, and exactly one of bios_we or cart_we, selected by the latched index.
  - Writes with ioctl_addr>=8192, or with any other index, are dropped with no RAM write. A dropped cart write still updates cart_size.
  - Cart writes set cart_size = max(cart_size, min(ioctl_addr+1, 8192)) at N+1.
  - ioctl_wait=0 in LOAD.
- Falling edge of ioctl_download:
  - If the index is CART_INDEX and cart_size<8192: go to FILL, with the fill pointer starting at cart_size.
  - Otherwise: go to POST.
  - A write strobe coincident with the falling edge is still accepted.
- FILL:
  - Each cycle: cart_we=1, cart_addr = pointer, mem_data = FILL_BYTE; then the pointer increments.
  - After the write to 8191, go to POST. Fill takes exactly 8192-cart_size cycles.
  - ioctl_wait=1 throughout FILL.
  - If ioctl_download rises during FILL, the fill completes first, then the FSM goes to LOAD (via IDLE).
- cart_mask is updated when FILL or POST is entered from a cart load:
  - cart_size<=2048: 13'h07FF.
  - cart_size<=4096: 13'h0FFF.
  - otherwise: 13'h1FFF.
  - cart_size==0 also gives 13'h07FF.
- POST: core_reset=1 for POST_CYCLES cycles, then IDLE.
- core_reset=1 in LOAD, FILL and POST; core_reset=0 only in IDLE.
- busy = (state != IDLE).
- Reset mid-operation: abort immediately to the reset values. Partial RAM contents remain; the next download reloads them.

Test Plan:
- Reset, then idle: core_reset=1 for 16 cycles after reset falls, then 0. In IDLE, cpu_cart_addr=13'h1234 -> cart_addr=13'h1234 (cart_mask=1FFF).
- BIOS download, 8192 bytes, index 0:
  - Required: 8192 bios_we pulses, each 1 cycle after its ioctl_wr; cart_we never asserts.
  - Required: no FILL; POST 16 cycles; cart_size unchanged.
- Cart download, 3000 bytes, index 1:
  - Required: cart_size=3000 and cart_mask=0FFF.
  - Required: FILL writes 0xFF to addresses 3000..8191 over 5192 cycles with ioctl_wait=1.
  - Required: after POST, cpu_cart_addr=13'h1ABC -> cart_addr=13'h0ABC.
- Cart download, 2048 bytes: cart_mask=07FF; cpu_cart_addr=13'h0800 -> cart_addr=0.
- Oversize cart, 10000 bytes: writes at addresses >=8192 are dropped; cart_size=8192; no FILL; cart_mask=1FFF.
- Reset asserted mid-FILL (pointer at 5000): next cycle cart_we=0, cart_size=0, cart_mask=1FFF, ioctl_wait=0; then POST for 16 cycles.
- Index 2 download: no RAM writes; core_reset high during download plus 16 cycles.
